// File: rtl/udp_rx_packet_queue.sv
// Receive-side payload buffer: stores parser bytes in a circular RAM, commits each packet on its
// last byte, rolls back dropped packets, and drains committed packets over a valid/ready stream.
module udp_rx_packet_queue #(
    parameter int DATA_DEPTH = 2048,
    parameter int MAX_PKTS   = 8,
    parameter int MAX_LEN    = 1472
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic                       in_abort,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(MAX_PKTS):0]  pkt_count,
    output logic [15:0]                drop_count
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int PW = AW + 1;
    localparam int QW = $clog2(MAX_PKTS);
    localparam int LW = ($clog2(MAX_LEN + 1) > 11) ? $clog2(MAX_LEN + 1) : 11;

    localparam logic [PW-1:0] DEPTH_P   = DATA_DEPTH[PW-1:0];
    localparam logic [QW:0]   PKTS_P    = MAX_PKTS[QW:0];
    localparam logic [LW-1:0] MAX_LEN_P = MAX_LEN[LW-1:0];

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DISCARD} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_OUT}     r_state_t;

    w_state_t      w_state;
    r_state_t      r_state;

    logic [7:0]    mem [DATA_DEPTH];
    logic [LW-1:0] lf_mem [MAX_PKTS];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] rd_ptr;
    logic [QW:0]   lf_wr;
    logic [QW:0]   lf_rd;
    logic [LW-1:0] len;
    logic [LW-1:0] rem;

    logic [PW-1:0] used;
    logic [PW-1:0] rd_addr;
    logic [LW-1:0] len_next;
    logic          buf_full;
    logic          len_over;
    logic          lf_full;
    logic          lf_empty;
    logic          pkt_open;
    logic          byte_drop;
    logic          drop;
    logic          accept;
    logic          commit;
    logic          out_fire;
    logic          last_fire;
    logic          pop;
    logic          rd_en;

    // Write-side decode. Capacity counts the packet the reader is still draining, so
    // pkt_count never exceeds MAX_PKTS and the length FIFO can never overflow.
    assign used      = wr_ptr - rd_ptr;
    assign buf_full  = (used == DEPTH_P);
    assign len_over  = (w_state == W_WRITE) && (len >= MAX_LEN_P);
    assign lf_full   = (pkt_count == PKTS_P);
    assign lf_empty  = (lf_wr == lf_rd);
    assign pkt_open  = (w_state == W_WRITE) || ((w_state == W_IDLE) && in_valid);
    assign byte_drop = in_valid && (buf_full || len_over || (in_last && lf_full));
    assign drop      = pkt_open && (in_abort || byte_drop);
    assign accept    = pkt_open && in_valid && !drop;
    assign commit    = accept && in_last;
    assign len_next  = (w_state == W_IDLE) ? LW'(1) : len + LW'(1);

    // Read-side decode; out_valid is high exactly while in R_OUT.
    assign out_fire  = (r_state == R_OUT) && out_ready;
    assign last_fire = out_fire && out_last;
    assign pop       = !lf_empty && ((r_state == R_IDLE) || last_fire);
    assign rd_en     = (r_state == R_FETCH) || (out_fire && !out_last);
    assign rd_addr   = (r_state == R_FETCH) ? rd_ptr : rd_ptr + PW'(1);

    // NOTE: storage arrays carry no reset; only the pointers that give them meaning are reset,
    // which keeps them mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
        if (commit) begin
            lf_mem[lf_wr[QW-1:0]] <= len_next;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers update
    // together from the values seen before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state    <= W_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            len        <= '0;
            lf_wr      <= '0;
            drop_count <= '0;
        end else if (drop) begin
            wr_ptr <= commit_ptr;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            w_state <= (in_abort || (in_valid && in_last)) ? W_IDLE : W_DISCARD;
        end else if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
            len    <= len_next;
            if (in_last) begin
                commit_ptr <= wr_ptr + PW'(1);
                lf_wr      <= lf_wr + (QW+1)'(1);
                w_state    <= W_IDLE;
            end else begin
                w_state <= W_WRITE;
            end
        end else if ((w_state == W_DISCARD) && (in_abort || (in_valid && in_last))) begin
            w_state <= W_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= R_IDLE;
            rd_ptr    <= '0;
            lf_rd     <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (pop) begin
                        rem     <= lf_mem[lf_rd[QW-1:0]];
                        lf_rd   <= lf_rd + (QW+1)'(1);
                        r_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    out_valid <= 1'b1;
                    out_last  <= (rem == LW'(1));
                    r_state   <= R_OUT;
                end
                R_OUT: begin
                    if (out_ready) begin
                        rd_ptr <= rd_ptr + PW'(1);
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (pop) begin
                                rem     <= lf_mem[lf_rd[QW-1:0]];
                                lf_rd   <= lf_rd + (QW+1)'(1);
                                r_state <= R_FETCH;
                            end else begin
                                r_state <= R_IDLE;
                            end
                        end else begin
                            rem      <= rem - LW'(1);
                            out_last <= (rem == LW'(2));
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // The RAM output register is the data output; it only reloads when a new byte is due,
    // so out_data holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
        end else if (rd_en) begin
            out_data <= mem[rd_addr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count <= '0;
        end else begin
            case ({commit, last_fire})
                2'b10:   pkt_count <= pkt_count + (QW+1)'(1);
                2'b01:   pkt_count <= pkt_count - (QW+1)'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_packet_queue.sv
// Self-checking bench for udp_rx_packet_queue: directed scenarios plus randomized batches
// scored against a packet-level reference model.
module tb_udp_rx_packet_queue;

    localparam int DATA_DEPTH = 16;
    localparam int MAX_PKTS   = 2;
    localparam int MAX_LEN    = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_abort = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic [1:0]  pkt_count;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    udp_rx_packet_queue #(
        .DATA_DEPTH(DATA_DEPTH),
        .MAX_PKTS  (MAX_PKTS),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_abort  (in_abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .pkt_count (pkt_count),
        .drop_count(drop_count)
    );

    int         total = 0;
    int         bad = 0;
    logic [8:0] exp_q[$];     // {last, data} of every byte the consumer should see, in order
    logic [7:0] pkt[$];       // payload of the packet about to be sent
    int         exp_drop = 0;
    int         bytes_held = 0;
    int         pkts_held = 0;
    logic       rand_ready = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshake about to happen, then move to 1 time unit past the edge.
    task automatic tick();
        logic [8:0] e;
        if (rand_ready) out_ready = 1'($urandom_range(1, 0));
        if (!reset) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                check("out_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_byte", {out_last, out_data}, e);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_abort = 1'b0;
        exp_q.delete();
        exp_drop   = 0;
        bytes_held = 0;
        pkts_held  = 0;
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_pkts", pkt_count, 0);
        check("rst_drops", drop_count, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic make_seq(input logic [7:0] start, input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(start + 8'(i));
    endtask

    task automatic make_rand(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    endtask

    // mode 0: normal packet; 1: bytes then a separate abort cycle; 2: abort on the last byte.
    // The model decides fate from the rules alone, assuming no bytes leave the buffer while the
    // batch is written (or that the batch stays within capacity).
    task automatic send_pkt(input int mode, input int gap_max);
        int len;
        len = pkt.size();
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = (i == len - 1) && (mode != 1);
            in_abort = (i == len - 1) && (mode == 2);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_abort = 1'b0;
            if (i != len - 1) repeat ($urandom_range(gap_max, 0)) tick();
        end
        if (mode == 1) begin
            in_abort = 1'b1;
            tick();
            in_abort = 1'b0;
        end
        if (mode != 0 || len > MAX_LEN || bytes_held + len > DATA_DEPTH || pkts_held == MAX_PKTS) begin
            if (exp_drop < 65535) exp_drop++;
        end else begin
            bytes_held += len;
            pkts_held++;
            for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, pkt[i]});
        end
    endtask

    // mode 0: always ready; 1: ready toggles every cycle; 2: random ready.
    task automatic drain(input int mode);
        int n;
        n = 0;
        rand_ready = 1'b0;
        while ((exp_q.size() != 0 || pkt_count != 0) && n < 1000) begin
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (n % 2 == 0);
            else                out_ready = 1'($urandom_range(1, 0));
            tick();
            n++;
        end
        check("drain_in_time", n < 1000, 1);
        out_ready = 1'b0;
        repeat (4) tick();
        check("idle_valid", out_valid, 0);
        check("idle_pkts", pkt_count, 0);
        check("idle_drops", drop_count, exp_drop);
        bytes_held = 0;
        pkts_held  = 0;
    endtask

    initial begin
        int lim;
        int budget;
        int kept;
        int mode;
        int len;

        do_reset();

        // T1: single packet with the consumer always ready
        out_ready = 1'b1;
        make_seq(8'h01, 5);
        send_pkt(0, 0);
        check("t1_pkt_count", pkt_count, 1);
        drain(0);
        check("t1_drops", drop_count, 0);

        // T2: backpressure toggling every cycle
        out_ready = 1'b0;
        make_seq(8'hA0, 4);
        send_pkt(0, 0);
        drain(1);

        // T3: stray idle abort is ignored, aborted packet is dropped, next packet passes
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        tick();
        check("t3_idle_abort", drop_count, 0);
        make_seq(8'h10, 3);
        send_pkt(1, 1);
        pkt.delete();
        pkt.push_back(8'hAA);
        pkt.push_back(8'hBB);
        send_pkt(0, 0);
        drain(0);
        check("t3_drops", drop_count, 1);

        // T4: second packet overflows the data RAM; then a packet wraps the pointer
        do_reset();
        out_ready = 1'b0;
        make_rand(10);
        send_pkt(0, 0);
        make_rand(10);
        send_pkt(0, 1);
        check("t4_drops", drop_count, 1);
        check("t4_pkts", pkt_count, 1);
        drain(0);
        make_rand(12);
        send_pkt(0, 1);
        drain(2);

        // T5: length FIFO full on the third 1-byte packet
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            make_seq(8'hC0 + 8'(i), 1);
            send_pkt(0, 0);
        end
        check("t5_pkts", pkt_count, 2);
        check("t5_drops", drop_count, 1);
        drain(1);

        // T6: reset mid-read and mid-write, then a clean packet
        out_ready = 1'b0;
        make_rand(6);
        send_pkt(0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("t6_pre_drops", drop_count, 1);
        do_reset();
        make_rand(7);
        send_pkt(0, 1);
        drain(2);

        // Randomized batches: even ones stream concurrently within capacity, odd ones stress drops
        for (int b = 0; b < 40; b++) begin
            if (b % 2 == 0) begin
                rand_ready = 1'b1;
                budget = DATA_DEPTH;
                kept = 0;
                for (int p = 0; p < 3; p++) begin
                    mode = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
                    if (mode == 0) begin
                        if (kept == MAX_PKTS || budget == 0) continue;
                        lim = (budget < MAX_LEN) ? budget : MAX_LEN;
                        len = $urandom_range(lim, 1);
                        budget -= len;
                        kept++;
                    end else begin
                        len = $urandom_range(6, 2);
                    end
                    make_rand(len);
                    send_pkt(mode, 2);
                    repeat ($urandom_range(2, 0)) tick();
                end
                drain(2);
            end else begin
                out_ready = 1'b0;
                for (int p = 0; p < int'($urandom_range(4, 1)); p++) begin
                    mode = ($urandom_range(5, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
                    len  = $urandom_range(16, 2);
                    make_rand(len);
                    send_pkt(mode, 1);
                    repeat ($urandom_range(1, 0)) tick();
                end
                check("rand_drops", drop_count, exp_drop);
                check("rand_pkts", pkt_count, pkts_held);
                drain(2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
